// File: rtl/ifu_fetch_arbiter.sv
// Shares the single instruction-memory port between the way0/way1 fetch units.
// Owns the fetch PC, alternates strictly way0 -> way1, and drops stale responses after a jump.
module ifu_fetch_arbiter #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             jumpFlag_i,
    input  logic [31:0]      jumpAddr_i,
    input  logic             way0_req_i,
    input  logic             way1_req_i,
    output logic             mem_req_o,
    output logic [31:0]      mem_addr_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [31:0]      mem_rdata_i,
    output logic             way0_valid_o,
    output logic [31:0]      way0_addr_o,
    output logic             way0_dataOk_o,
    output logic [31:0]      way0_inst_o,
    output logic             way1_valid_o,
    output logic [31:0]      way1_addr_o,
    output logic             way1_dataOk_o,
    output logic [31:0]      way1_inst_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {ISSUE, WAIT, DROP} state_t;

    state_t            state, state_n;
    logic [31:0]       pc, pc_n;
    logic              turn, turn_n;
    logic [CNT_W-1:0]  drop_n;
    logic [31:0]       inst0_q, inst1_q;
    logic              cur_req, resp_ok, drop_evt;

    assign cur_req    = turn ? way1_req_i : way0_req_i;
    assign mem_req_o  = (state == ISSUE) && cur_req && !jumpFlag_i;
    assign mem_addr_o = pc;

    // A jump in the rvalid cycle kills the response, so dataOk is gated by the jump.
    assign resp_ok       = (state == WAIT) && mem_rvalid_i && !jumpFlag_i;
    assign way0_dataOk_o = resp_ok && !turn;
    assign way1_dataOk_o = resp_ok && turn;
    assign way0_inst_o   = way0_dataOk_o ? mem_rdata_i : inst0_q;
    assign way1_inst_o   = way1_dataOk_o ? mem_rdata_i : inst1_q;

    assign drop_evt = mem_rvalid_i &&
                      (((state == WAIT) && jumpFlag_i) || (state == DROP));

    assign way0_valid_o = (state != DROP) && !turn;
    assign way1_valid_o = (state != DROP) && turn;
    assign busy_o       = (state != ISSUE);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        turn_n  = turn;
        case (state)
            ISSUE: if (mem_req_o && mem_gnt_i) state_n = WAIT;
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_n = ISSUE;
                    if (!jumpFlag_i) begin
                        pc_n   = pc + 32'd4;
                        turn_n = ~turn;
                    end
                end else if (jumpFlag_i) begin
                    state_n = DROP;
                end
            end
            // The outstanding response retires the drop even if another jump lands with it.
            DROP:    if (mem_rvalid_i) state_n = ISSUE;
            default: state_n = ISSUE;
        endcase
        if (jumpFlag_i) begin
            pc_n   = {jumpAddr_i[31:2], 2'b00};
            turn_n = 1'b0;
        end
    end

    always_comb begin
        drop_n = drop_cnt_o;
        if (drop_evt && (drop_cnt_o != {CNT_W{1'b1}}))
            drop_n = drop_cnt_o + CNT_W'(1);
    end

    // Address outputs are loaded from next-state so they track pc in the cycle it is live.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ISSUE;
            pc          <= RESET_PC;
            turn        <= 1'b0;
            drop_cnt_o  <= '0;
            inst0_q     <= '0;
            inst1_q     <= '0;
            way0_addr_o <= '0;
            way1_addr_o <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            turn       <= turn_n;
            drop_cnt_o <= drop_n;
            if (way0_dataOk_o) inst0_q <= mem_rdata_i;
            if (way1_dataOk_o) inst1_q <= mem_rdata_i;
            if (state_n != DROP && !turn_n) way0_addr_o <= pc_n;
            if (state_n != DROP && turn_n)  way1_addr_o <= pc_n;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_arbiter.sv
// Directed bench for ifu_fetch_arbiter: a per-cycle vector table plus hand sequences
// for async reset in WAIT, held-address checks and drop counter saturation.
module tb_ifu_fetch_arbiter;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          jumpFlag_i;
    logic [31:0]   jumpAddr_i;
    logic          way0_req_i, way1_req_i;
    logic          mem_req_o;
    logic [31:0]   mem_addr_o;
    logic          mem_gnt_i, mem_rvalid_i;
    logic [31:0]   mem_rdata_i;
    logic          way0_valid_o, way0_dataOk_o, way1_valid_o, way1_dataOk_o;
    logic [31:0]   way0_addr_o, way0_inst_o, way1_addr_o, way1_inst_o;
    logic [CW-1:0] drop_cnt_o;
    logic          busy_o;

    int tests = 0;
    int fails = 0;

    ifu_fetch_arbiter #(.RESET_PC(32'h8000_0000), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .jumpFlag_i(jumpFlag_i), .jumpAddr_i(jumpAddr_i),
        .way0_req_i(way0_req_i), .way1_req_i(way1_req_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .way0_valid_o(way0_valid_o), .way0_addr_o(way0_addr_o),
        .way0_dataOk_o(way0_dataOk_o), .way0_inst_o(way0_inst_o),
        .way1_valid_o(way1_valid_o), .way1_addr_o(way1_addr_o),
        .way1_dataOk_o(way1_dataOk_o), .way1_inst_o(way1_inst_o),
        .drop_cnt_o(drop_cnt_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        j;
        logic [31:0] ja;
        logic        r0, r1, g, rv;
        logic [31:0] rd;
        logic        req;
        logic [31:0] addr;
        logic        ok0, ok1, v0, v1, busy;
        logic [2:0]  drop;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic v(input logic j, input logic [31:0] ja, input logic r0, input logic r1,
                     input logic g, input logic rv, input logic [31:0] rd,
                     input logic req, input logic [31:0] addr, input logic ok0, input logic ok1,
                     input logic v0, input logic v1, input logic busy, input logic [2:0] drop);
        vec_t e;
        e.j = j; e.ja = ja; e.r0 = r0; e.r1 = r1; e.g = g; e.rv = rv; e.rd = rd;
        e.req = req; e.addr = addr; e.ok0 = ok0; e.ok1 = ok1;
        e.v0 = v0; e.v1 = v1; e.busy = busy; e.drop = drop;
        vecs.push_back(e);
    endtask

    task automatic drive(input logic j, input logic [31:0] ja, input logic r0, input logic r1,
                         input logic g, input logic rv, input logic [31:0] rd);
        jumpFlag_i = j; jumpAddr_i = ja; way0_req_i = r0; way1_req_i = r1;
        mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;
    endtask

    initial begin
        logic [31:0] last0, last1;
        logic [2:0]  exp_drop;
        last0 = 32'h0;
        last1 = 32'h0;

        //  j  ja            r0 r1 g  rv rd            req addr          ok0 ok1 v0 v1 busy drop
        v(0, 32'h0,          1, 1, 1, 0, 32'h0,        1, 32'h8000_0000, 0, 0, 1, 0, 0, 0);
        v(0, 32'h0,          1, 1, 0, 1, 32'hA000_0000,0, 32'h0,         1, 0, 1, 0, 1, 0);
        v(0, 32'h0,          1, 1, 1, 0, 32'h0,        1, 32'h8000_0004, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,          1, 1, 0, 1, 32'hA000_0001,0, 32'h0,         0, 1, 0, 1, 1, 0);
        v(0, 32'h0,          1, 1, 1, 0, 32'h0,        1, 32'h8000_0008, 0, 0, 1, 0, 0, 0);
        v(0, 32'h0,          1, 1, 0, 1, 32'hA000_0002,0, 32'h0,         1, 0, 1, 0, 1, 0);
        // way1's turn but way1 idle: no request, way0 must not be served
        for (int i = 0; i < 5; i++)
            v(0, 32'h0,      1, 0, 1, 0, 32'h0,        0, 32'h0,         0, 0, 0, 1, 0, 0);
        v(0, 32'h0,          1, 1, 1, 0, 32'h0,        1, 32'h8000_000C, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,          1, 1, 0, 1, 32'hB000_0001,0, 32'h0,         0, 1, 0, 1, 1, 0);
        // jump while waiting, response lands two cycles later and is dropped
        v(0, 32'h0,          1, 1, 1, 0, 32'h0,        1, 32'h8000_0010, 0, 0, 1, 0, 0, 0);
        v(1, 32'h8000_1006,  1, 1, 0, 0, 32'h0,        0, 32'h0,         0, 0, 1, 0, 1, 0);
        v(0, 32'h0,          1, 1, 0, 0, 32'h0,        0, 32'h0,         0, 0, 0, 0, 1, 0);
        v(0, 32'h0,          1, 1, 1, 1, 32'hDEAD_0000,0, 32'h0,         0, 0, 0, 0, 1, 0);
        // grant stall, then a jump moves the held address
        for (int i = 0; i < 4; i++)
            v(0, 32'h0,      1, 1, 0, 0, 32'h0,        1, 32'h8000_1004, 0, 0, 1, 0, 0, 1);
        v(1, 32'h8000_2000,  1, 1, 1, 0, 32'h0,        0, 32'h0,         0, 0, 1, 0, 0, 1);
        v(0, 32'h0,          1, 1, 0, 0, 32'h0,        1, 32'h8000_2000, 0, 0, 1, 0, 0, 1);
        v(0, 32'h0,          1, 1, 1, 0, 32'h0,        1, 32'h8000_2000, 0, 0, 1, 0, 0, 1);
        // jump in the rvalid cycle
        v(1, 32'h8000_3000,  1, 1, 0, 1, 32'hBAD0_0000,0, 32'h0,         0, 0, 1, 0, 1, 1);
        v(0, 32'h0,          1, 1, 1, 0, 32'h0,        1, 32'h8000_3000, 0, 0, 1, 0, 0, 2);
        v(0, 32'h0,          1, 1, 0, 1, 32'hC000_0000,0, 32'h0,         1, 0, 1, 0, 1, 2);

        drive(0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        #12;
        chk("rst_req", {31'b0, mem_req_o}, 32'h0);
        chk("rst_addr", mem_addr_o, 32'h8000_0000);
        chk("rst_ok", {30'b0, way0_dataOk_o, way1_dataOk_o}, 32'h0);
        chk("rst_busy", {31'b0, busy_o}, 32'h0);
        chk("rst_drop", {29'b0, drop_cnt_o}, 32'h0);
        chk("rst_inst0", way0_inst_o, 32'h0);
        chk("rst_inst1", way1_inst_o, 32'h0);
        chk("rst_waddr", way0_addr_o | way1_addr_o, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].j, vecs[k].ja, vecs[k].r0, vecs[k].r1, vecs[k].g, vecs[k].rv, vecs[k].rd);
            #2;
            if (vecs[k].ok0) last0 = vecs[k].rd;
            if (vecs[k].ok1) last1 = vecs[k].rd;
            chk($sformatf("v%0d_req", k), {31'b0, mem_req_o}, {31'b0, vecs[k].req});
            if (vecs[k].req) chk($sformatf("v%0d_addr", k), mem_addr_o, vecs[k].addr);
            chk($sformatf("v%0d_ok", k), {30'b0, way0_dataOk_o, way1_dataOk_o},
                {30'b0, vecs[k].ok0, vecs[k].ok1});
            chk($sformatf("v%0d_valid", k), {30'b0, way0_valid_o, way1_valid_o},
                {30'b0, vecs[k].v0, vecs[k].v1});
            chk($sformatf("v%0d_busy", k), {31'b0, busy_o}, {31'b0, vecs[k].busy});
            chk($sformatf("v%0d_drop", k), {29'b0, drop_cnt_o}, {29'b0, vecs[k].drop});
            chk($sformatf("v%0d_inst0", k), way0_inst_o, last0);
            chk($sformatf("v%0d_inst1", k), way1_inst_o, last1);
        end

        // way1 now live at the next address, way0 holds its last one
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("hold_addr0", way0_addr_o, 32'h8000_3000);
        chk("live_addr1", way1_addr_o, 32'h8000_3004);
        chk("hold_inst0", way0_inst_o, 32'hC000_0000);

        // async reset while waiting, then a late rvalid must be ignored
        @(negedge clk);
        drive(0, 0, 0, 1, 1, 0, 0);
        #2;
        chk("mw_req", {31'b0, mem_req_o}, 32'h1);
        chk("mw_addr", mem_addr_o, 32'h8000_3004);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("mw_busy", {31'b0, busy_o}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mw_rst_busy", {31'b0, busy_o}, 32'h0);
        chk("mw_rst_pc", mem_addr_o, 32'h8000_0000);
        chk("mw_rst_drop", {29'b0, drop_cnt_o}, 32'h0);
        chk("mw_rst_inst1", way1_inst_o, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 32'h1234_5678);
        #2;
        chk("mw_late_ok", {30'b0, way0_dataOk_o, way1_dataOk_o}, 32'h0);
        chk("mw_late_busy", {31'b0, busy_o}, 32'h0);

        // drop counter saturates at all-ones
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(0, 0, 1, 0, 1, 0, 0);
            #2;
            chk($sformatf("sat%0d_req", i), {31'b0, mem_req_o}, 32'h1);
            @(negedge clk);
            drive(1, 32'h8000_4000, 0, 0, 0, 1, 32'hFFFF_0000);
            #2;
            chk($sformatf("sat%0d_ok", i), {30'b0, way0_dataOk_o, way1_dataOk_o}, 32'h0);
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0);
            #2;
            exp_drop = (i + 1 > 7) ? 3'd7 : 3'(i + 1);
            chk($sformatf("sat%0d_drop", i), {29'b0, drop_cnt_o}, {29'b0, exp_drop});
            chk($sformatf("sat%0d_pc", i), mem_addr_o, 32'h8000_4000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
